seg_display_ctrl: RTL and testbench

//  Parametrised multi-digit 7-segment display controller; successor to the fixed 6-digit hex decoder.

---
 rtl/seg_display_pkg.sv | 37 +++
 rtl/seg_glyph_rom.sv | 15 +
 rtl/seg_display_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multi-digit 7-segment display controller.
package seg_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_UPDATE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef logic [15:0][6:0] glyph_table_t;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   function automatic glyph_table_t glyph_table();
      glyph_table_t t;
      t[0]  = 7'b1000000;
      t[1]  = 7'b1111001;
      t[2]  = 7'b0100100;
      t[3]  = 7'b0110000;
      t[4]  = 7'b0011001;
      t[5]  = 7'b0010010;
      t[6]  = 7'b0000010;
      t[7]  = 7'b1111000;
      t[8]  = 7'b0000000;
      t[9]  = 7'b0011000;
      t[10] = 7'b0001000;
      t[11] = 7'b0000011;
      t[12] = 7'b1000110;
      t[13] = 7'b0100001;
      t[14] = 7'b0000110;
      t[15] = 7'b0001110;
      return t;
   endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Nibble to active-low 7-segment glyph lookup.
module seg_glyph_rom
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph_c
);

   localparam glyph_table_t GLYPHS = glyph_table();

   always_comb begin
      glyph_c = GLYPHS[nibble];
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: hex or double-dabble decimal display with
// leading-zero blanking and overflow dashes. Blinking is built only with SEG_BLINK_EN.
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BLINK_HZ   = 2
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    load_dec,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   localparam int unsigned BIN_W      = 4 * NUM_DIGITS;
   localparam int unsigned BCD_DIGITS = NUM_DIGITS + NUM_DIGITS / 4 + 1;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
   localparam int unsigned CNT_W      = $clog2(BIN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t                  state_q, state_d;
   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    dec_q, dec_d;
   logic                    blz_q, blz_d;
   logic [BIN_W-1:0]        digit_q, digit_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic                    ovf_d;
   logic                    ready_d;
   logic [BIN_W-1:0]        src_digits;
   logic [NUM_DIGITS-1:0]   blank_calc;
   logic                    lz_run;
   logic                    blink_off;

   logic [NUM_DIGITS-1:0][6:0] glyph_c;
   logic [NUM_DIGITS-1:0][6:0] seg_d;

   // Double-dabble adjust step: +3 on every BCD nibble >= 5
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digits to commit, and leading-zero blanking scanned from the top digit down
   always_comb begin
      src_digits = dec_q ? bcd_q[BIN_W-1:0] : bin_q;
      lz_run     = blz_q;
      blank_calc = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         lz_run        = lz_run && (src_digits[4*i +: 4] == 4'd0);
         blank_calc[i] = lz_run && (i != 0);
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      blz_d   = blz_q;
      digit_d = digit_q;
      blank_d = blank_q;
      ovf_d   = overflow;
      ready_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_valid && load_ready) begin
               bin_d   = load_value;
               dec_d   = load_dec;
               blz_d   = blank_lz;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = load_dec ? ST_CONVERT : ST_UPDATE;
            end
         end
         ST_CONVERT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            digit_d = src_digits;
            blank_d = blank_calc;
            ovf_d   = dec_q && (|bcd_q[BCD_W-1:BIN_W]);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   // Blank register resets to all ones so the display stays dark until the first load
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dec_q      <= 1'b0;
         blz_q      <= 1'b0;
         digit_q    <= '0;
         blank_q    <= '1;
         overflow   <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         dec_q      <= dec_d;
         blz_q      <= blz_d;
         digit_q    <= digit_d;
         blank_q    <= blank_d;
         overflow   <= ovf_d;
         load_ready <= ready_d;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int unsigned HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned PRE_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_PERIOD - 1);

   logic [PRE_W-1:0] pre_q;
   logic             phase_on_q;

   // Blink prescaler: phase toggles every HALF_PERIOD cycles
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pre_q      <= '0;
         phase_on_q <= 1'b1;
      end else if (pre_q == PRE_LAST) begin
         pre_q      <= '0;
         phase_on_q <= ~phase_on_q;
      end else begin
         pre_q      <= pre_q + 1'b1;
      end
   end

   assign blink_off = ~phase_on_q;
`else
   assign blink_off = 1'b0;
`endif

   for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_rom
      seg_glyph_rom u_rom (
         .nibble  (digit_q[4*g +: 4]),
         .glyph_c (glyph_c[g])
      );
   end

   // Per-digit segment selection: blank beats dash beats glyph; blink gates last
   always_comb begin
      seg_d = '1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (blank_q[i]) begin
            seg_d[i] = SEG_BLANK;
         end else if (overflow) begin
            seg_d[i] = SEG_DASH;
         end else begin
            seg_d[i] = glyph_c[i];
         end
         if (blink_off && blink_mask[i]) begin
            seg_d[i] = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         hex_out <= '1;
      end else begin
         hex_out <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: vector table, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_seg_display_ctrl;

   localparam int unsigned N        = 6;
   localparam int unsigned CLK_HZ   = 16;
   localparam int unsigned BLINK_HZ = 2;
   localparam int unsigned HALF     = CLK_HZ / (2 * BLINK_HZ);
`ifdef SEG_BLINK_EN
   localparam bit BLINK_BUILT = 1'b1;
`else
   localparam bit BLINK_BUILT = 1'b0;
`endif

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0011000, GA = 7'b0001000, GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
   localparam logic [6:0] BL = 7'h7F, DS = 7'h3F;

   logic          clk = 1'b0;
   logic          reset, load_valid, load_ready, load_dec, blank_lz, overflow;
   logic [4*N-1:0] load_value;
   logic [N-1:0]   blink_mask;
   logic [7*N-1:0] hex_out;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   int unsigned m_busy = 0, m_ecount = 0;
   bit          m_valid = 0, m_dec = 0, m_blz = 0, p_dec = 0, p_blz = 0;
   logic [23:0] m_val = '0, p_val = '0;

   typedef struct {
      logic [23:0] value;
      bit          dec;
      bit          blz;
      logic [41:0] exp_seg;
      bit          exp_ovf;
   } vec_t;
   vec_t vecs[11];

   always #5 clk = ~clk;

   seg_display_ctrl #(.NUM_DIGITS(N), .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .load_dec   (load_dec),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .overflow   (overflow),
      .hex_out    (hex_out)
   );

   function automatic logic [6:0] glyph_of(input int unsigned d);
      case (d)
         0: return G0;  1: return G1;  2: return G2;  3: return G3;
         4: return G4;  5: return G5;  6: return G6;  7: return G7;
         8: return G8;  9: return G9;  10: return GA; 11: return GB;
         12: return GC; 13: return GD; 14: return GE; default: return GF;
      endcase
   endfunction

   function automatic bit phase_on_at(input int unsigned e);
      return !BLINK_BUILT || (((e / HALF) % 2) == 0);
   endfunction

   // Display image computed by positional arithmetic on the shown value
   function automatic logic [41:0] render(input bit valid, input logic [23:0] val, input bit dec,
                                          input bit blz, input logic [5:0] mask, input bit on);
      logic [5:0][6:0] s;
      int unsigned rest, base;
      bit ovf;
      if (!valid) return '1;
      base = dec ? 10 : 16;
      ovf  = dec && (val >= 24'd1000000);
      rest = dec ? (int'(val) % 1000000) : int'(val);
      for (int i = 0; i < 6; i++) begin
         if (i > 0 && blz && rest == 0) s[i] = BL;
         else if (ovf)                  s[i] = DS;
         else                           s[i] = glyph_of(rest % base);
         if (!on && mask[i]) s[i] = BL;
         rest = rest / base;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare
   task automatic step();
      logic [41:0] exp_hex;
      @(posedge clk);
      if (reset) begin
         m_busy = 0; m_valid = 0; m_ecount = 0; exp_hex = '1;
      end else begin
         exp_hex = render(m_valid, m_val, m_dec, m_blz, blink_mask, phase_on_at(m_ecount));
         m_ecount++;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1; m_val = p_val; m_dec = p_dec; m_blz = p_blz;
            end
         end else if (load_valid) begin
            p_val = load_value; p_dec = load_dec; p_blz = blank_lz;
            m_busy = load_dec ? 4 * N + 1 : 1;
         end
      end
      #1;
      check("hex_out", hex_out, exp_hex);
      check("load_ready", load_ready, m_busy == 0);
      check("overflow", overflow, m_valid && m_dec && (m_val >= 24'd1000000));
   endtask

   task automatic do_load(input logic [23:0] v, input bit dec, input bit blz);
      int n = 0;
      while (!load_ready && n < 60) begin step(); n++; end
      load_value = v; load_dec = dec; blank_lz = blz; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!load_ready && n < 60) begin step(); n++; end
      check("ready_timeout", n < 60, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, blanks, lit, other_bad;
      reset = 1; load_valid = 0; load_value = '0; load_dec = 0; blank_lz = 0; blink_mask = '0;
      step(); step();
      check("reset_hex", hex_out, {7*N{1'b1}});
      check("reset_ready", load_ready, 1);
      check("reset_ovf", overflow, 0);
      reset = 0;
      step();

      vecs[0]  = '{24'h12AB3F, 1'b0, 1'b0, {G1, G2, GA, GB, G3, GF}, 1'b0};
      vecs[1]  = '{24'd123456, 1'b1, 1'b0, {G1, G2, G3, G4, G5, G6}, 1'b0};
      vecs[2]  = '{24'd1000000, 1'b1, 1'b0, {6{DS}}, 1'b1};
      vecs[3]  = '{24'h000042, 1'b0, 1'b1, {BL, BL, BL, BL, G4, G2}, 1'b0};
      vecs[4]  = '{24'h000000, 1'b0, 1'b1, {BL, BL, BL, BL, BL, G0}, 1'b0};
      vecs[5]  = '{24'd0, 1'b1, 1'b0, {6{G0}}, 1'b0};
      vecs[6]  = '{24'd999999, 1'b1, 1'b1, {6{G9}}, 1'b0};
      vecs[7]  = '{24'd1000, 1'b1, 1'b1, {BL, BL, G1, G0, G0, G0}, 1'b0};
      vecs[8]  = '{24'd1000000, 1'b1, 1'b1, {BL, BL, BL, BL, BL, DS}, 1'b1};
      vecs[9]  = '{24'hFFFFFF, 1'b1, 1'b0, {6{DS}}, 1'b1};
      vecs[10] = '{24'h00F000, 1'b0, 1'b1, {BL, BL, GF, G0, G0, G0}, 1'b0};

      foreach (vecs[k]) begin
         do_load(vecs[k].value, vecs[k].dec, vecs[k].blz);
         wait_ready(n);
         check($sformatf("vec%0d_latency", k), n, vecs[k].dec ? 4 * N + 1 : 1);
         step();
         check($sformatf("vec%0d_hex", k), hex_out, vecs[k].exp_seg);
         check($sformatf("vec%0d_ovf", k), overflow, vecs[k].exp_ovf);
      end

      // blink on digit 0 only
      do_load(24'h12AB3F, 1'b0, 1'b0);
      wait_ready(n);
      blink_mask = 6'b000001;
      step(); step();
      blanks = 0; lit = 0; other_bad = 0;
      for (int c = 0; c < 4 * HALF; c++) begin
         step();
         if (hex_out[6:0] == BL) blanks++;
         else if (hex_out[6:0] == GF) lit++;
         if (hex_out[41:7] != {G1, G2, GA, GB, G3}) other_bad++;
      end
      check("blink_off_cycles", blanks, BLINK_BUILT ? 2 * HALF : 0);
      check("blink_on_cycles", lit, BLINK_BUILT ? 2 * HALF : 4 * HALF);
      check("blink_others_steady", other_bad, 0);
      blink_mask = '0;

      // a load request during conversion is dropped
      do_load(24'd123456, 1'b1, 1'b0);
      repeat (5) step();
      load_value = 24'd654321; load_dec = 1'b0; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      wait_ready(n);
      step();
      check("drop_hex", hex_out, {G1, G2, G3, G4, G5, G6});
      repeat (4) step();
      check("drop_hold", hex_out, {G1, G2, G3, G4, G5, G6});

      // reset in the middle of a conversion, with overflow previously set
      do_load(24'd1000000, 1'b1, 1'b0);
      wait_ready(n);
      step();
      check("pre_reset_ovf", overflow, 1);
      do_load(24'd654321, 1'b1, 1'b0);
      repeat (10) step();
      reset = 1;
      step();
      check("midreset_ready", load_ready, 1);
      check("midreset_hex", hex_out, {7*N{1'b1}});
      check("midreset_ovf", overflow, 0);
      reset = 0;
      repeat (3) step();
      do_load(24'hABCDEF, 1'b0, 1'b0);
      wait_ready(n);
      step();
      check("post_reset_hex", hex_out, {GA, GB, GC, GD, GE, GF});

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         reset      = ($urandom % 300) == 0;
         load_valid = ($urandom % 3) == 0;
         load_dec   = $urandom % 2;
         blank_lz   = $urandom % 2;
         case ($urandom % 4)
            0:       load_value = 24'($urandom % 1000000);
            1:       load_value = 24'(999990 + $urandom % 20);
            2:       load_value = 24'($urandom);
            default: load_value = 24'($urandom % 300);
         endcase
         if (($urandom % 8) == 0) blink_mask = 6'($urandom);
         step();
      end
      reset = 0; load_valid = 0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
